// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU operations, mux selects,
// multi-cycle controller states and the branch condition helper.
package riscv_pkg;

   typedef enum logic [6:0] {
      RType    = 7'b0110011,
      Load     = 7'b0000011,
      IType    = 7'b0010011,
      SType    = 7'b0100011,
      BType    = 7'b1100011,
      AddUpp   = 7'b0010111,  // auipc
      LoadUpp  = 7'b0110111,  // lui
      JumpImm  = 7'b1101111,  // jal
      JumpLink = 7'b1100111   // jalr
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_READDATA  = 2'b01,
      RES_ALURESULT = 2'b10,
      RES_IMMEXT    = 2'b11
   } result_src_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd14
   } mcstate_t;

   // ALU operand A / B select encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Branch outcome from the ALU flags; 010/011 are not branches and never take.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lt,
                                         input logic       ltu);
      case (funct3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder_v2.sv
// ALU operation decode from funct3/funct7[5]. op5 separates register
// (sub allowed) from immediate forms, where only srai looks at funct7[5].
module alu_decoder_v2
   import riscv_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op5,
   input  logic       is_branch,
   output alu_op_t    alu_control
);

   // Map funct fields onto an ALU operation; branches always compare by subtracting.
   always_comb begin
      // NOTE: default assigned first so every path drives the output and no latch is inferred.
      alu_control = ALU_ADD;
      if (is_branch) begin
         alu_control = ALU_SUB;
      end else begin
         case (funct3)
            3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I controller: sequences each instruction through the shared
// memory and single ALU, stalls on mem_ready_i, traps on illegal opcodes and
// memory timeouts. Outputs are decoded from state; FETCH enables and branch
// PCWrite are additionally gated by the current-cycle inputs.
module multicycle_control_fsm
   import riscv_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_WIDTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic                   zero_i,
   input  logic                   lt_i,
   input  logic                   ltu_i,
   input  logic                   mem_ready_i,
   output logic                   PCWrite_o,
   output logic                   AdrSrc_o,
   output logic                   MemRead_o,
   output logic                   MemWrite_o,
   output logic                   IRWrite_o,
   output logic [1:0]             ResultSrc_o,
   output logic [1:0]             ALUSrcA_o,
   output logic [1:0]             ALUSrcB_o,
   output logic [3:0]             ALUControl_o,
   output logic [2:0]             ImmSrc_o,
   output logic                   RegWrite_o,
   output logic                   trap_o,
   output logic [3:0]             state_o
);

   mcstate_t            state, state_next;
   logic [TO_WIDTH-1:0] to_cnt;
   logic                trap;
   logic                waiting;
   logic                timeout_hit;
   alu_op_t             alu_sel;

   logic [2:0] funct3;
   logic       funct7_5;
   logic       op5;
   logic       unused_instr;

   assign funct3       = instr_i[14:12];
   assign funct7_5     = instr_i[30];
   assign op5          = instr_i[5];
   assign unused_instr = ^{instr_i[INSTR_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

   assign waiting     = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   // A ready in the same cycle takes priority, so timeout only fires without it.
   assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && !mem_ready_i &&
                        (to_cnt == TO_WIDTH'(MEM_TIMEOUT));

   alu_decoder_v2 u_alu_dec (
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .op5         (op5),
      .is_branch   (state == S_BRANCH),
      .alu_control (alu_sel)
   );

   // Next-state selection.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: begin
            if (mem_ready_i)      state_next = S_DECODE;
            else if (timeout_hit) state_next = S_TRAP;
         end
         S_DECODE: begin
            case (instr_i[6:0])
               Load, SType: state_next = S_MEMADR;
               RType:       state_next = S_EXECR;
               IType:       state_next = S_EXECI;
               BType:       state_next = S_BRANCH;
               JumpImm:     state_next = S_JAL;
               JumpLink:    state_next = S_JALR;
               LoadUpp:     state_next = S_LUI;
               AddUpp:      state_next = S_AUIPC;
               default:     state_next = S_TRAP;
            endcase
         end
         S_MEMADR:   state_next = op5 ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            if (mem_ready_i)      state_next = S_MEMWB;
            else if (timeout_hit) state_next = S_TRAP;
         end
         S_MEMWRITE: begin
            if (mem_ready_i)      state_next = S_FETCH;
            else if (timeout_hit) state_next = S_TRAP;
         end
         S_MEMWB, S_ALUWB, S_LUI:              state_next = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_JALR, S_AUIPC: state_next = S_ALUWB;
         S_BRANCH:   state_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
         default:    state_next = S_TRAP;
      endcase
   end

   // State, memory-wait counter and sticky trap flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_FETCH;
         to_cnt <= '0;
         trap   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_next;
         if (state_next != state)
            to_cnt <= '0;
         else if (waiting && !mem_ready_i && (to_cnt != '1))
            to_cnt <= to_cnt + TO_WIDTH'(1);
         if (state_next == S_TRAP)
            trap <= 1'b1;
      end
   end

   // Datapath control decode; everything is forced low while rst is high.
   always_comb begin
      PCWrite_o    = 1'b0;
      AdrSrc_o     = 1'b0;
      MemRead_o    = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      ResultSrc_o  = RES_ALUOUT;
      ALUSrcA_o    = SRCA_PC;
      ALUSrcB_o    = SRCB_RS2;
      ALUControl_o = ALU_ADD;
      ImmSrc_o     = IMM_I;
      RegWrite_o   = 1'b0;
      trap_o       = 1'b0;
      state_o      = '0;
      if (!rst) begin
         trap_o  = trap;
         state_o = state;
         case (state)
            S_FETCH: begin
               MemRead_o   = 1'b1;
               ALUSrcB_o   = SRCB_FOUR;
               ResultSrc_o = RES_ALURESULT;
               IRWrite_o   = mem_ready_i;
               PCWrite_o   = mem_ready_i;
            end
            S_DECODE: begin
               ALUSrcA_o = SRCA_OLDPC;
               ALUSrcB_o = SRCB_IMM;
               ImmSrc_o  = IMM_B;
            end
            S_MEMADR: begin
               ALUSrcA_o = SRCA_RS1;
               ALUSrcB_o = SRCB_IMM;
               ImmSrc_o  = op5 ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
               AdrSrc_o  = 1'b1;
               MemRead_o = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc_o = RES_READDATA;
               RegWrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
               AdrSrc_o   = 1'b1;
               MemWrite_o = 1'b1;
            end
            S_EXECR: begin
               ALUSrcA_o    = SRCA_RS1;
               ALUControl_o = alu_sel;
            end
            S_EXECI: begin
               // Immediate ops still take rs1 as the first operand.
               ALUSrcA_o    = SRCA_RS1;
               ALUSrcB_o    = SRCB_IMM;
               ALUControl_o = alu_sel;
            end
            S_ALUWB: begin
               RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA_o    = SRCA_RS1;
               ALUControl_o = alu_sel;
               PCWrite_o    = branch_taken(funct3, zero_i, lt_i, ltu_i);
            end
            S_JAL: begin
               ALUSrcA_o = SRCA_OLDPC;
               ALUSrcB_o = SRCB_FOUR;
               PCWrite_o = 1'b1;
            end
            S_JALR: begin
               ALUSrcA_o   = SRCA_RS1;
               ALUSrcB_o   = SRCB_IMM;
               ResultSrc_o = RES_ALURESULT;
               PCWrite_o   = 1'b1;
            end
            S_LUI: begin
               ImmSrc_o    = IMM_U;
               ResultSrc_o = RES_IMMEXT;
               RegWrite_o  = 1'b1;
            end
            S_AUIPC: begin
               ALUSrcA_o = SRCA_OLDPC;
               ALUSrcB_o = SRCB_IMM;
               ImmSrc_o  = IMM_U;
            end
            default: ;  // TRAP: every enable stays low
         endcase
      end
   end

endmodule
